// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared definitions for the GF(257) 4x24 LDPC decoder control path.
// Holds the decoder geometry and the 3-bit phase sequencer state encoding.
package ldpc_pkg;

    // Decoder geometry: 24 variable-node columns, 4 check rows.
    localparam int COLS = 24;
    localparam int ROWS = 4;

    // Phase sequencer states.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_GAP_I = 3'd2;
    localparam logic [2:0] S_VPU   = 3'd3;
    localparam logic [2:0] S_GAP_V = 3'd4;
    localparam logic [2:0] S_CPU   = 3'd5;
    localparam logic [2:0] S_CHECK = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

endpackage

// File: rtl/ldpc_phase_ctrl_phase_timer.sv
// phase_timer: per-phase cycle counter shared by every sequencer phase.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : restart the count at 0 on the next cycle
//   term       : terminal count (phase length - 1)
//   last       : high while the count equals term (final cycle of the phase)
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] term,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last = (cnt_q == term);

endmodule

// File: rtl/ldpc_phase_ctrl.sv
// ldpc_phase_ctrl: phase sequencer for the GF(257) 4x24 LDPC decoder.
// Runs one INIT pass, then VPU / CPU passes per iteration until the syndrome
// is zero or the iteration limit is hit.
//   start     : one-cycle decode request, accepted only in IDLE
//   abort     : return to IDLE from any busy state (beats start and parity_ok)
//   max_iter  : iteration limit, latched at start (0 behaves as 1)
//   parity_ok : syndrome-zero flag, looked at only in CHECK
//   en/busy   : high whenever the sequencer is not IDLE
//   initial_on, vpu_on, cpu_on : mutually exclusive phase strobes
//   done      : one-cycle completion pulse
//   success   : parity_ok of the final CHECK, held until next start
//   iter_cnt  : completed iterations, held until next start
//   state_dbg : current sequencer state
// Handshake: start is a request with no acknowledge; it is acted on only
// when the sequencer sits in IDLE and abort is low in the same cycle.
module ldpc_phase_ctrl
    import ldpc_pkg::*;
#(
    parameter int INIT_LEN = COLS,
    parameter int VPU_LEN  = COLS,
    parameter int CPU_LEN  = ROWS,
    parameter int GAP_LEN  = 2,
    parameter int ITER_W   = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              parity_ok,
    output logic              en,
    output logic              initial_on,
    output logic              vpu_on,
    output logic              cpu_on,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [2:0]        state_dbg
);

    localparam logic [CNT_W-1:0] INIT_T = CNT_W'(INIT_LEN - 1);
    localparam logic [CNT_W-1:0] VPU_T  = CNT_W'(VPU_LEN - 1);
    localparam logic [CNT_W-1:0] CPU_T  = CNT_W'(CPU_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [ITER_W-1:0] lim_q;
    logic [CNT_W-1:0]  term;
    logic              load, last, accept;

    assign accept = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        term = '0;
        case (state_q)
            S_INIT:          term = INIT_T;
            S_GAP_I,S_GAP_V: term = GAP_T;
            S_VPU:           term = VPU_T;
            S_CPU:           term = CPU_T;
            default:         term = '0;
        endcase
    end

    // The timer restarts on every state change so each phase counts from 0.
    assign load = (state_d != state_q) || (state_q == S_IDLE);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .term  (term),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (accept) state_d = S_INIT;
        end else if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_INIT:  if (last) state_d = (GAP_LEN == 0) ? S_VPU : S_GAP_I;
                S_GAP_I: if (last) state_d = S_VPU;
                S_VPU:   if (last) state_d = (GAP_LEN == 0) ? S_CPU : S_GAP_V;
                S_GAP_V: if (last) state_d = S_CPU;
                S_CPU:   if (last) state_d = S_CHECK;
                S_CHECK: state_d = (parity_ok || (iter_cnt + ITER_W'(1) == lim_q))
                                   ? S_DONE : S_VPU;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lim_q      <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            initial_on <= 1'b0;
            vpu_on     <= 1'b0;
            cpu_on     <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            iter_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            en         <= (state_d != S_IDLE);
            busy       <= (state_d != S_IDLE);
            initial_on <= (state_d == S_INIT);
            vpu_on     <= (state_d == S_VPU);
            cpu_on     <= (state_d == S_CPU);
            done       <= (state_d == S_DONE);
            if (accept) begin
                lim_q    <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                iter_cnt <= '0;
                success  <= 1'b0;
            end else if (state_q != S_IDLE && abort) begin
                success <= 1'b0;
            end else if (state_q == S_CHECK) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
                if (state_d == S_DONE) success <= parity_ok;
            end
        end
    end

    assign state_dbg = state_q;

endmodule

// File: doc/ldpc_phase_ctrl.md
Name: ldpc_phase_ctrl

Overview:
- Top-level phase sequencer for the GF(257) 4x24 LDPC decoder; sits directly upstream of vpu_addr_gen and the check-node stage.
- Generates the en / initial_on / vpu_on strobes that drive vpu_addr_gen, plus cpu_on for the check-node stage.
- Sequences one initialisation pass, then alternating VPU/CPU passes per iteration, until parity passes or the iteration limit is reached; reports done and the iteration count.

Parameters:
- INIT_LEN, 24, cycles initial_on stays high (one column per cycle across 24 columns).
- VPU_LEN, 24, cycles vpu_on stays high per iteration.
- CPU_LEN, 4, cycles cpu_on stays high per iteration (4 check rows).
- GAP_LEN, 2, idle cycles after each INIT or VPU pass, for pipeline drain of address gen / memory.
- ITER_W, 5, width of max_iter and iter_cnt.
- CNT_W, 8, width of the internal phase counter; must hold max(INIT_LEN, VPU_LEN, CPU_LEN, GAP_LEN)-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset; sampled on rising clk.
- start  in  1  one-cycle request to decode a new frame; honoured only in IDLE.
- abort  in  1  force return to IDLE.
- max_iter  in  ITER_W  iteration limit; sampled at start; 0 is treated as 1.
- parity_ok  in  1  syndrome-zero flag from the check stage; sampled only in CHECK.
- en  out  1  block enable to vpu_addr_gen; high whenever state != IDLE.
- initial_on  out  1  high during INIT.
- vpu_on  out  1  high during VPU.
- cpu_on  out  1  high during CPU.
- busy  out  1  equals en.
- done  out  1  one-cycle pulse at decode completion.
- success  out  1  parity_ok result of the final CHECK; held until next start.
- iter_cnt  out  ITER_W  number of completed iterations; held until next start.

Behaviour:
- All outputs are registered and all are 0 after reset.
- rst_n low at any clk edge: state=IDLE, all counters and outputs 0, including mid-decode.
- States: IDLE, INIT, GAP_I, VPU, GAP_V, CPU, CHECK, DONE.
- Phase counter loads 0 on state entry. A state of length L exits on the cycle with counter==L-1, so its strobe is high for exactly L cycles.
- IDLE, start=1: latch max(max_iter,1) into lim_q, clear iter_cnt and success, go to INIT. Outputs rise on the cycle after start.
- INIT (initial_on=1, INIT_LEN cycles) -> GAP_I (GAP_LEN cycles, all strobes 0, en=1) -> VPU.
- VPU (vpu_on=1, VPU_LEN cycles) -> GAP_V (GAP_LEN cycles) -> CPU (cpu_on=1, CPU_LEN cycles) -> CHECK (1 cycle, strobes 0). In CHECK, iter_cnt increments.
- CHECK: if parity_ok=1 or iter_cnt+1==lim_q, go to DONE with success<=parity_ok. Otherwise go to VPU.
- DONE: done=1 for one cycle, en still 1; next state IDLE.
- initial_on, vpu_on and cpu_on are mutually exclusive in every cycle.
- GAP_LEN=0: GAP states are skipped and the next phase follows directly.
- abort=1 in any non-IDLE state: next state IDLE, strobes 0, done stays 0, iter_cnt holds, success=0. abort has priority over parity_ok.
- start while busy: ignored. start and abort both high in IDLE: abort wins and state stays IDLE.
- iter_cnt never exceeds lim_q, so there is no wrap.

Decomposition:
- Shared package ldpc_pkg holds the state encoding (3-bit localparams) and the decoder geometry constants (COLS=24, ROWS=4), used as defaults for INIT_LEN, VPU_LEN and CPU_LEN.
- One natural sub-module: phase_timer (load/clear, count to programmable terminal, emits last-cycle flag), instantiated once and reused across all phases.
- The FSM stays in ldpc_phase_ctrl.

Test Plan:
- Reset mid-decode: start, hold rst_n=0 for 1 cycle during VPU -> next cycle all outputs 0 and state IDLE; a later start runs a full sequence from INIT.
- Single iteration, defaults: max_iter=1, parity_ok=0, start at cycle 0 -> initial_on high for cycles 1-24; vpu_on high for 27-50; cpu_on high for 53-56; CHECK at 57; done at 58 with success=0, iter_cnt=1; en low from 59.
- Early exit: max_iter=10, parity_ok=1 asserted in the 3rd CHECK -> done pulses once, iter_cnt=3, success=1; exactly 3 vpu_on bursts of 24 cycles each.
- Limit and zero: max_iter=0 -> behaves as 1 (iter_cnt=1). max_iter=31, parity_ok=0 -> iter_cnt=31, success=0.
- Abort/start interaction: abort during CPU of iteration 2 -> IDLE next cycle, done never pulses, iter_cnt=1. start pulsed during VPU -> no restart and the sequence is unchanged.
- Continuous assertion: initial_on+vpu_on+cpu_on <= 1 every cycle. With GAP_LEN=0, vpu_on rises on the cycle after initial_on falls.
